// File: rtl/italos_pkg.sv
// italos_pkg: shared scan-code constants, FSM state types and glyph lookup for the iTalos video path.
package italos_pkg;

    localparam logic [7:0] KC_F       = 8'h2B;
    localparam logic [7:0] KC_Q       = 8'h15;
    localparam logic [7:0] KC_H       = 8'h33;
    localparam logic [7:0] KC_X       = 8'h22;
    localparam logic [7:0] KC_BREAK   = 8'hF0;
    localparam logic [7:0] KC_EXT     = 8'hE0;
    localparam logic [7:0] CHAR_BLANK = 8'h00;

    typedef enum logic [1:0] {P_NORM, P_BRK, P_EXT, P_EXTBRK} parser_state_t;
    typedef enum logic [1:0] {D_IDLE, D_SHOW, D_GAP} disp_state_t;

    function automatic logic is_glyph(input logic [7:0] c);
        return c == KC_F || c == KC_Q || c == KC_H || c == KC_X;
    endfunction

endpackage

// File: rtl/char_fifo.sv
// char_fifo: synchronous show-ahead FIFO.
// Ports: Pixelclock/reset (async, active-high); push/din write, pop reads dout (head, combinational);
// full/empty flags; count = occupancy. A push while full is taken only if a pop happens in the same cycle.
module char_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     Pixelclock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic             wr, rd;

    assign rd    = pop && !empty;
    assign wr    = push && (!full || rd);
    assign full  = count == CW'(DEPTH);
    assign empty = count == '0;
    assign dout  = mem[rptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge Pixelclock or posedge reset)
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr) wptr <= wptr + 1'b1;
            if (rd) rptr <= rptr + 1'b1;
            count <= count + CW'(wr) - CW'(rd);
        end

    always_ff @(posedge Pixelclock)
        if (wr) mem[wptr] <= din;

endmodule

// File: rtl/char_display_sequencer.sv
// char_display_sequencer: parses PS/2 scan codes, queues glyphs and shows each for HOLD_FRAMES frames then a GAP_FRAMES blank.
// Ports: Pixelclock, reset (async, active-high); key_code/key_valid scan-code byte strobe; frame_start frame strobe;
// character = glyph to mask generator (00 blank); busy = display active or queue non-empty; overflow = sticky drop flag;
// fifo_count = queue occupancy. Optional macro CHAR_SEQ_REPEAT_FILTER_EN suppresses typematic repeats of the held key.
import italos_pkg::*;

module char_display_sequencer #(
    parameter int FIFO_DEPTH  = 4,
    parameter int HOLD_FRAMES = 60,
    parameter int GAP_FRAMES  = 6
) (
    input  logic                         Pixelclock,
    input  logic                         reset,
    input  logic [7:0]                   key_code,
    input  logic                         key_valid,
    input  logic                         frame_start,
    output logic [7:0]                   character,
    output logic                         busy,
    output logic                         overflow,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    parser_state_t p, p_nxt;
    disp_state_t   d, d_nxt;
    logic [7:0]    fcnt, fcnt_nxt, char_nxt, head;
    logic          push, pop, full, empty, accept, repeat_hit, busy_nxt;
    logic [CW-1:0] count_nxt;

`ifdef CHAR_SEQ_REPEAT_FILTER_EN
    logic [7:0] held, held_nxt;

    assign repeat_hit = key_code == held;

    always_comb begin
        held_nxt = held;
        if (key_valid && p == P_NORM && is_glyph(key_code) && !repeat_hit) held_nxt = key_code;
        if (key_valid && p == P_BRK && key_code == held) held_nxt = CHAR_BLANK;
    end

    always_ff @(posedge Pixelclock or posedge reset)
        if (reset) held <= CHAR_BLANK;
        else held <= held_nxt;
`else
    assign repeat_hit = 1'b0;
`endif

    always_comb begin
        p_nxt = p;
        push  = 1'b0;
        if (key_valid)
            case (p)
                P_NORM: begin
                    p_nxt = key_code == KC_BREAK ? P_BRK : key_code == KC_EXT ? P_EXT : P_NORM;
                    push  = is_glyph(key_code) && !repeat_hit;
                end
                P_EXT:   p_nxt = key_code == KC_BREAK ? P_EXTBRK : P_NORM;
                default: p_nxt = P_NORM;
            endcase
    end

    always_comb begin
        d_nxt    = d;
        fcnt_nxt = fcnt;
        char_nxt = character;
        pop      = 1'b0;
        if (frame_start)
            case (d)
                D_IDLE:
                    if (!empty) begin
                        pop      = 1'b1;
                        char_nxt = head;
                        fcnt_nxt = '0;
                        d_nxt    = D_SHOW;
                    end
                D_SHOW:
                    if (fcnt == 8'(HOLD_FRAMES - 1)) begin
                        char_nxt = CHAR_BLANK;
                        fcnt_nxt = '0;
                        d_nxt    = D_GAP;
                    end else fcnt_nxt = fcnt + 8'd1;
                D_GAP:
                    if (fcnt == 8'(GAP_FRAMES - 1)) d_nxt = D_IDLE;
                    else fcnt_nxt = fcnt + 8'd1;
                default: d_nxt = D_IDLE;
            endcase
    end

    // busy is registered from next-state values so it tracks fifo_count and the FSM in the same cycle.
    assign accept    = push && (!full || pop);
    assign count_nxt = fifo_count + CW'(accept) - CW'(pop);
    assign busy_nxt  = d_nxt != D_IDLE || count_nxt != '0;

    always_ff @(posedge Pixelclock or posedge reset)
        if (reset) begin
            p         <= P_NORM;
            d         <= D_IDLE;
            fcnt      <= '0;
            character <= CHAR_BLANK;
            busy      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            p         <= p_nxt;
            d         <= d_nxt;
            fcnt      <= fcnt_nxt;
            character <= char_nxt;
            busy      <= busy_nxt;
            if (push && !accept) overflow <= 1'b1;
        end

    char_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .Pixelclock (Pixelclock),
        .reset      (reset),
        .push       (push),
        .pop        (pop),
        .din        (key_code),
        .dout       (head),
        .full       (full),
        .empty      (empty),
        .count      (fifo_count)
    );

endmodule

// File: tb/tb_char_display_sequencer.sv
// tb_char_display_sequencer: scoreboard bench; stimulus queues expected character changes, a monitor checks them and hold length.
module tb_char_display_sequencer;
    localparam int HOLD = 60;
    localparam int GLYPH_FRAMES = 67;

    logic       Pixelclock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] key_code = 8'h00;
    logic       key_valid = 1'b0;
    logic       frame_start = 1'b0;
    logic [7:0] character;
    logic       busy, overflow;
    logic [2:0] fifo_count;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];
    logic [7:0] prev = 8'h00;
    int         frames = 0;
    logic       fs;
    logic [7:0] e;

    char_display_sequencer dut (
        .Pixelclock  (Pixelclock),
        .reset       (reset),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .frame_start (frame_start),
        .character   (character),
        .busy        (busy),
        .overflow    (overflow),
        .fifo_count  (fifo_count)
    );

    always #5 Pixelclock = ~Pixelclock;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", n, act, req);
        end
    endtask

    task automatic send_key(input logic [7:0] c);
        @(negedge Pixelclock);
        key_code  = c;
        key_valid = 1'b1;
        @(negedge Pixelclock);
        key_valid = 1'b0;
    endtask

    task automatic run_frames(input int n);
        repeat (n) begin
            @(negedge Pixelclock);
            frame_start = 1'b1;
            @(negedge Pixelclock);
            frame_start = 1'b0;
            repeat (2) @(negedge Pixelclock);
        end
    endtask

    task automatic do_reset();
        @(negedge Pixelclock);
        reset = 1'b1;
        repeat (2) @(negedge Pixelclock);
        reset = 1'b0;
    endtask

    task automatic expect_glyph(input logic [7:0] c);
        exp_q.push_back(c);
        exp_q.push_back(8'h00);
    endtask

    // Monitor: every change of character pops the scoreboard; a glyph-to-blank change also checks the hold length.
    initial forever begin
        @(posedge Pixelclock);
        fs = frame_start;
        #1;
        if (reset) prev = 8'h00;
        else begin
            if (fs) frames++;
            if (character != prev) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_char actual=%0h required=none", character);
                end else begin
                    e = exp_q.pop_front();
                    chk("char_seq", character, e);
                end
                if (prev != 8'h00 && character == 8'h00) chk("hold_frames", frames, HOLD);
                prev   = character;
                frames = 0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge Pixelclock);
        reset = 1'b0;
        #1;
        chk("rst_char", character, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_count", fifo_count, 3'd0);

        expect_glyph(8'h2B);
        send_key(8'h2B);
        chk("push_count", fifo_count, 3'd1);
        chk("push_busy", busy, 1'b1);
        run_frames(66);
        chk("gap_busy", busy, 1'b1);
        run_frames(1);
        chk("idle_busy", busy, 1'b0);
        run_frames(3);
        chk("single_end_char", character, 8'h00);

        do_reset();
        send_key(8'hF0); send_key(8'h2B);
        send_key(8'hE0); send_key(8'h75);
        send_key(8'hE0); send_key(8'hF0); send_key(8'h75);
        chk("brk_count", fifo_count, 3'd0);
        chk("brk_busy", busy, 1'b0);
        run_frames(3);
        chk("brk_char", character, 8'h00);

        do_reset();
`ifdef CHAR_SEQ_REPEAT_FILTER_EN
        repeat (2) expect_glyph(8'h33);
`else
        repeat (4) expect_glyph(8'h33);
`endif
        send_key(8'h33); send_key(8'h33); send_key(8'h33);
        send_key(8'hF0); send_key(8'h33); send_key(8'h33);
`ifdef CHAR_SEQ_REPEAT_FILTER_EN
        chk("rep_count", fifo_count, 3'd2);
`else
        chk("rep_count", fifo_count, 3'd4);
`endif
        run_frames(GLYPH_FRAMES * 4 + 1);
        chk("rep_busy", busy, 1'b0);
        chk("rep_q_empty", exp_q.size(), 0);

        do_reset();
        expect_glyph(8'h2B); expect_glyph(8'h15); expect_glyph(8'h33); expect_glyph(8'h22);
        send_key(8'h2B); send_key(8'h15); send_key(8'h33); send_key(8'h22); send_key(8'h2B);
        chk("ovf_count", fifo_count, 3'd4);
        chk("ovf_flag", overflow, 1'b1);
        run_frames(GLYPH_FRAMES * 4 + 1);
        chk("ovf_sticky", overflow, 1'b1);
        chk("ovf_busy", busy, 1'b0);
        chk("ovf_q_empty", exp_q.size(), 0);

        do_reset();
        expect_glyph(8'h2B); expect_glyph(8'h15); expect_glyph(8'h33); expect_glyph(8'h22); expect_glyph(8'h15);
        send_key(8'h2B); send_key(8'h15); send_key(8'h33); send_key(8'h22);
        chk("full_count", fifo_count, 3'd4);
        @(negedge Pixelclock);
        key_code    = 8'h15;
        key_valid   = 1'b1;
        frame_start = 1'b1;
        @(negedge Pixelclock);
        key_valid   = 1'b0;
        frame_start = 1'b0;
        chk("sim_count", fifo_count, 3'd4);
        chk("sim_ovf", overflow, 1'b0);
        run_frames(GLYPH_FRAMES * 5);
        chk("sim_busy", busy, 1'b0);
        chk("sim_q_empty", exp_q.size(), 0);

        do_reset();
        expect_glyph(8'h2B);
        send_key(8'h2B); send_key(8'h15); send_key(8'h33);
        run_frames(3);
        chk("mid_count", fifo_count, 3'd2);
        @(negedge Pixelclock);
        reset = 1'b1;
        exp_q.delete();
        @(negedge Pixelclock);
        chk("mid_rst_char", character, 8'h00);
        chk("mid_rst_count", fifo_count, 3'd0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_ovf", overflow, 1'b0);
        @(negedge Pixelclock);
        reset = 1'b0;
        run_frames(3);
        chk("mid_after_char", character, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
